serial_word_collector: RTL and testbench

//   Downstream consumer of the 8-bit load/shift register chain. Samples the serial bit

---
 rtl/serial_word_collector.sv | 129 ++++++++++++
 tb/tb_serial_word_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector: reassembles LSB-first serial bits into WIDTH-bit words and
// presents each word through a one-deep valid/ready hold buffer with a sticky overflow flag.
module serial_word_collector #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_in_bit,
  input  logic             i_shift,
  input  logic             i_load_n,
  input  logic             i_data_ready,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_valid,
  output logic [CntW-1:0]  o_bit_count,
  output logic             o_overflow
);

  typedef enum logic {StEmpty, StFull} hold_state_e;

  // Assembly side
  logic [WIDTH-1:0] r_asm;
  logic [CntW-1:0]  r_bit_count;

  // Output side
  logic [WIDTH-1:0] r_data;
  hold_state_e      r_state;
  logic             r_overflow;

  logic             w_capture;
  logic             w_flush;
  logic             w_last_bit;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;

  hold_state_e      w_state_d;
  logic             w_load_data;
  logic             w_drop;

  // The oldest assembly bit falls off the bottom when the word completes; it is never read.
  logic             w_unused_asm_lsb;

  // Shifter loading invalidates the partial word, whatever the shift strobe does.
  assign w_flush    = ~i_load_n;
  assign w_capture  = i_load_n & i_shift;
  assign w_last_bit = (r_bit_count == CntW'(WIDTH - 1));
  assign w_complete = w_capture & w_last_bit;
  assign w_word     = {i_in_bit, r_asm[WIDTH-1:1]};
  assign w_unused_asm_lsb = r_asm[0];

  // Assembly register and bit counter: capture, flush or hold.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_asm       <= '0;
      r_bit_count <= '0;
    end else if (w_flush) begin
      r_asm       <= '0;
      r_bit_count <= '0;
    end else if (w_capture) begin
      r_asm <= w_word;
      if (w_last_bit) begin
        r_bit_count <= '0;
      end else begin
        r_bit_count <= r_bit_count + CntW'(1);
      end
    end
  end

  // Hold-buffer next state: decides whether a completed word is loaded, kept or dropped.
  always_comb begin
    w_state_d   = r_state;
    w_load_data = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_complete) begin
          w_state_d   = StFull;
          w_load_data = 1'b1;
        end
      end
      StFull: begin
        if (w_complete) begin
          // Back-to-back: accept and refill on the same edge keeps the buffer full.
          if (i_data_ready) begin
            w_load_data = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (i_data_ready) begin
          w_state_d = StEmpty;
        end
      end
      default: begin
        w_state_d = StEmpty;
      end
    endcase
  end

  // Hold-buffer state register and data; data keeps its value after a pop.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= StEmpty;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load_data) begin
        r_data <= w_word;
      end
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = (r_state == StFull);
  assign o_bit_count  = r_bit_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: directed scenarios plus random stimulus, checked against a
// queue-based model of the bit stream with a scoreboard of delivered words.
module tb_serial_word_collector;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk;
  logic          reset_n;
  logic          in_bit;
  logic          shift;
  logic          load_n;
  logic          data_ready;
  logic          ovf_clr;
  logic [W-1:0]  data;
  logic          data_valid;
  logic [CW-1:0] bit_count;
  logic          overflow;

  serial_word_collector #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_in_bit     (in_bit),
    .i_shift      (shift),
    .i_load_n     (load_n),
    .i_data_ready (data_ready),
    .i_ovf_clr    (ovf_clr),
    .o_data       (data),
    .o_data_valid (data_valid),
    .o_bit_count  (bit_count),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received so far, buffer occupancy, sticky flag.
  bit           m_bits[$];
  bit           m_full;
  bit           m_ovf;
  logic [W-1:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit b, input bit s, input bit l,
                            input bit rdy, input bit clr);
    bit           complete;
    bit           dropped;
    logic [W-1:0] word;
    complete = 1'b0;
    dropped  = 1'b0;
    word     = '0;
    if (!r) begin
      m_bits.delete();
      m_full = 1'b0;
      m_ovf  = 1'b0;
      sb.delete();
    end else begin
      if (!l) begin
        m_bits.delete();
      end else if (s) begin
        m_bits.push_back(b);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) word[i] = m_bits[i];
          m_bits.delete();
          complete = 1'b1;
        end
      end
      if (complete) begin
        if (!m_full || rdy) begin
          m_full = 1'b1;
          sb.push_back(word);
        end else begin
          dropped = 1'b1;
        end
      end else if (m_full && rdy) begin
        m_full = 1'b0;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  endtask

  // One clock: check state left by the previous edge, then drive and model the next edge.
  task automatic step(input bit r, input bit b, input bit s, input bit l,
                      input bit rdy, input bit clr);
    @(negedge clk);
    chk("bit_count", int'(bit_count), m_bits.size());
    chk("data_valid", int'(data_valid), int'(m_full));
    chk("overflow", int'(overflow), int'(m_ovf));
    reset_n    = r;
    in_bit     = b;
    shift      = s;
    load_n     = l;
    data_ready = rdy;
    ovf_clr    = clr;
    model_step(r, b, s, l, rdy, clr);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy_last, input int gap);
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[i], 1'b1, 1'b1, (i == W - 1) ? rdy_last : 1'b0, 1'b0);
      for (int g = 0; g < gap; g++) idle();
    end
    idle();
  endtask

  // Monitor: a word is taken on the next edge when valid, ready and not in reset.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (data_valid === 1'b1 && data_ready === 1'b1 && reset_n === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h expected=none at %0t", data, $time);
        end else begin
          chk("popped_data", int'(data), int'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    in_bit     = 1'b0;
    shift      = 1'b0;
    load_n     = 1'b1;
    data_ready = 1'b0;
    ovf_clr    = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Basic word 0xA5 (bits 1,0,1,0,0,1,0,1).
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'hA5, 1'b0, 0);
    @(negedge clk);
    chk("t1_data", int'(data), 'hA5);
    chk("t1_valid", int'(data_valid), 1);
    chk("t1_ovf", int'(overflow), 0);

    // Full buffer, no ready: 0x5A is dropped and overflow set, then cleared.
    send_word(8'h5A, 1'b0, 0);
    @(negedge clk);
    chk("t4_data", int'(data), 'hA5);
    chk("t4_ovf", int'(overflow), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("t4_ovf_clr", int'(overflow), 0);

    // Pop, then gapped strobes for 0x3C.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(8'h3C, 1'b0, 2);
    @(negedge clk);
    chk("t2_data", int'(data), 'h3C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 5 bits, flush, then 0x81.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("t3_flush_cnt", int'(bit_count), 0);
    send_word(8'h81, 1'b0, 0);
    @(negedge clk);
    chk("t3_data", int'(data), 'h81);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Hold 0x11, accept it on the edge that completes 0x22.
    send_word(8'h11, 1'b0, 0);
    send_word(8'h22, 1'b1, 0);
    @(negedge clk);
    chk("t5_data", int'(data), 'h22);
    chk("t5_valid", int'(data_valid), 1);
    chk("t5_ovf", int'(overflow), 0);

    // Reset mid-word with a word pending.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("t6_data", int'(data), 0);
    chk("t6_valid", int'(data_valid), 0);
    chk("t6_cnt", int'(bit_count), 0);
    chk("t6_ovf", int'(overflow), 0);
    send_word(8'hC3, 1'b0, 0);
    @(negedge clk);
    chk("t6_clean_word", int'(data), 'hC3);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(63) != 0, 1'($urandom), $urandom_range(1) == 1,
           $urandom_range(15) != 0, $urandom_range(2) == 0, $urandom_range(15) == 0);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
